// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for the data RAM arbiter: CPU MEM-stage port, host/debug port
// and the single-port RAM side.
interface data_mem_arbiter_if #(
    parameter int RAM_AW = 10,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              host_req;
    logic              host_we;
    logic [31:0]       host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    logic [RAM_AW-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvalid,
        output ram_address, ram_data, ram_wren,
        input  ram_q
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvalid,
        input  ram_address, ram_data, ram_wren,
        output ram_q
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data RAM between the MEM stage and the host port,
// with a bounded host wait and one-cycle read return routing.
module data_mem_arbiter #(
    parameter int RAM_AW   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input logic               clk,
    input logic               rst,
    data_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        CPU_RD,
        HOST_RD
    } own_t;

    own_t              own;
    logic [2:0]        wait_cnt;
    logic              host_pri;
    logic              cpu_win;
    logic              host_win;
    logic [DATA_W-1:0] rd_zero;

    assign host_pri = 32'(wait_cnt) >= 32'(MAX_WAIT);
    assign rd_zero  = '0;

    // Grants are forced off while reset is held
    always_comb begin
        cpu_win  = 1'b0;
        host_win = 1'b0;
        if (rst) begin
            if (bus.cpu_req && bus.host_req) begin
                host_win = host_pri;
                cpu_win  = ~host_pri;
            end else begin
                cpu_win  = bus.cpu_req;
                host_win = bus.host_req;
            end
        end
    end

    always_comb begin
        bus.ram_address = '0;
        bus.ram_data    = '0;
        bus.ram_wren    = 1'b0;
        unique case (1'b1)
            cpu_win: begin
                bus.ram_address = bus.cpu_addr[RAM_AW+1:2];
                bus.ram_data    = bus.cpu_wdata;
                bus.ram_wren    = bus.cpu_we;
            end
            host_win: begin
                bus.ram_address = bus.host_addr[RAM_AW+1:2];
                bus.ram_data    = bus.host_wdata;
                bus.ram_wren    = bus.host_we;
            end
            default: ;
        endcase
    end

    assign bus.cpu_stall = rst & bus.cpu_req & ~cpu_win;
    assign bus.host_gnt  = host_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own      <= IDLE;
            wait_cnt <= 3'd0;
        end else begin
            if (cpu_win && !bus.cpu_we)
                own <= CPU_RD;
            else if (host_win && !bus.host_we)
                own <= HOST_RD;
            else
                own <= IDLE;

            if (bus.host_req && !host_win) begin
                if (wait_cnt != 3'd7)
                    wait_cnt <= wait_cnt + 3'd1;
            end else begin
                wait_cnt <= 3'd0;
            end
        end
    end

    // Return data follows whichever port owns the in-flight read
    assign bus.cpu_rvalid  = (own == CPU_RD);
    assign bus.host_rvalid = (own == HOST_RD);
    assign bus.cpu_rdata   = bus.cpu_rvalid  ? bus.ram_q : rd_zero;
    assign bus.host_rdata  = bus.host_rvalid ? bus.ram_q : rd_zero;

    logic unused_addr;
    assign unused_addr = ^{bus.cpu_addr[31:RAM_AW+2], bus.cpu_addr[1:0],
                           bus.host_addr[31:RAM_AW+2], bus.host_addr[1:0]};

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: directed scenarios plus random
// traffic checked against a transaction-level model of the shared RAM.
module tb_data_mem_arbiter;

    localparam int RAM_AW   = 10;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << RAM_AW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.RAM_AW(RAM_AW), .DATA_W(DATA_W)) bus ();

    data_mem_arbiter #(
        .RAM_AW(RAM_AW),
        .DATA_W(DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    function automatic logic [31:0] init_word(input logic [RAM_AW-1:0] a);
        return 32'hA5A50000 ^ (32'(a) * 32'h00010003);
    endfunction

    // Registered-read RAM behind the arbiter
    logic [31:0] tram [DEPTH];
    bit          twr  [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_wren) begin
            tram[bus.ram_address] <= bus.ram_data;
            twr[bus.ram_address]  <= 1'b1;
        end
        bus.ram_q <= twr[bus.ram_address] ? tram[bus.ram_address]
                                          : init_word(bus.ram_address);
    end

    typedef struct {
        int          cyc;
        logic        stall;
        logic        gnt;
        logic        wren;
        logic [9:0]  addr;
        logic [31:0] data;
    } grant_t;

    typedef struct {
        int          due;
        bit          host;
        logic [31:0] data;
    } read_t;

    grant_t exp_g[$];
    read_t  exp_rd[$];

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [31:0] rm [DEPTH];
    bit          rw [DEPTH];
    int          streak = 0;
    bit          last_cg = 0;
    bit          last_hg = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h",
                      name, cyc, act, exp);
    endtask

    function automatic logic [31:0] ref_word(input logic [RAM_AW-1:0] a);
        return rw[a] ? rm[a] : init_word(a);
    endfunction

    // One clock of stimulus; the model decides the winner from the host's
    // current losing streak and queues the expected bus and read results.
    task automatic cycle(input bit r,
                         input bit cr, input bit cw,
                         input logic [31:0] ca, input logic [31:0] cwd,
                         input bit hr, input bit hw,
                         input logic [31:0] ha, input logic [31:0] hwd);
        grant_t g;
        bit cg, hg, rd;
        @(posedge clk);
        cyc++;
        #1;
        rst            = r;
        bus.cpu_req    = cr;
        bus.cpu_we     = cw;
        bus.cpu_addr   = ca;
        bus.cpu_wdata  = cwd;
        bus.host_req   = hr;
        bus.host_we    = hw;
        bus.host_addr  = ha;
        bus.host_wdata = hwd;
        g = '{cyc: cyc, stall: 0, gnt: 0, wren: 0, addr: '0, data: '0};
        cg = 0;
        hg = 0;
        if (!r) begin
            streak = 0;
            exp_rd.delete();
        end else begin
            if (cr && hr) begin
                hg = (streak >= MAX_WAIT);
                cg = !hg;
            end else begin
                cg = cr;
                hg = hr;
            end
            rd = 0;
            if (cg) begin
                g.wren = cw; g.addr = ca[11:2]; g.data = cwd; rd = !cw;
            end else if (hg) begin
                g.wren = hw; g.addr = ha[11:2]; g.data = hwd; rd = !hw;
            end
            g.stall = cr && !cg;
            g.gnt   = hg;
            if (rd) exp_rd.push_back('{due: cyc + 1, host: hg,
                                       data: ref_word(g.addr)});
            if (g.wren) begin
                rm[g.addr] = g.data;
                rw[g.addr] = 1'b1;
            end
            if (hr && !hg) streak = (streak < 7) ? streak + 1 : 7;
            else streak = 0;
        end
        exp_g.push_back(g);
        last_cg = cg;
        last_hg = hg;
    endtask

    task automatic idle(input bit r);
        cycle(r, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) << 2;
        a = a | ($urandom & 32'h3);
        if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFFF000);
        return a;
    endfunction

    // Monitor: bus outputs against the queued grant, returns against reads
    initial begin
        grant_t g;
        read_t  e;
        forever begin
            @(negedge clk);
            if (exp_g.size() > 0) begin
                g = exp_g.pop_front();
                chk("grant",
                    {bus.cpu_stall, bus.host_gnt, bus.ram_wren,
                     bus.ram_address, bus.ram_data},
                    {g.stall, g.gnt, g.wren, g.addr, g.data});
            end
            if (exp_rd.size() > 0 && exp_rd[0].due == cyc) begin
                e = exp_rd.pop_front();
                chk(e.host ? "rd_host" : "rd_cpu",
                    {bus.cpu_rvalid, bus.cpu_rdata,
                     bus.host_rvalid, bus.host_rdata},
                    e.host ? {1'b0, 32'h0, 1'b1, e.data}
                           : {1'b1, e.data, 1'b0, 32'h0});
            end else begin
                chk("rd_idle",
                    {bus.cpu_rvalid, bus.cpu_rdata,
                     bus.host_rvalid, bus.host_rdata},
                    66'h0);
            end
        end
    end

    initial begin
        bit cr, cw, hr, hw, r;
        logic [31:0] ca, cwd, ha, hwd;
        int n;

        bus.cpu_req    = 0; bus.cpu_we  = 0;
        bus.cpu_addr   = 0; bus.cpu_wdata  = 0;
        bus.host_req   = 0; bus.host_we = 0;
        bus.host_addr  = 0; bus.host_wdata = 0;
        for (int i = 0; i < DEPTH; i++) rw[i] = 1'b0;

        // Held in reset with both ports requesting
        repeat (3) cycle(0, 1, 1, 32'h44, 32'h1234, 1, 1, 32'h88, 32'h5678);

        // CPU read of 0x10 right after release
        cycle(1, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        idle(1);

        // Store then load the same word
        cycle(1, 1, 1, 32'h20, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
        cycle(1, 1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0);
        idle(1);

        // Host starved by continuous CPU reads until the bound
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            cycle(1, 1, 0, rnd_addr(), 32'h0, 1, 0, 32'h40, 32'h0);
            @(negedge clk);
            #1;
            if (bus.host_gnt === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("starve_len", 128'(n), 128'(MAX_WAIT + 1));
        cycle(1, 1, 0, 32'h3C, 32'h0, 0, 0, 32'h0, 32'h0);
        idle(1);

        // Alternating read owners on consecutive cycles
        cycle(1, 1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        cycle(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h4, 32'h0);
        idle(1);

        // Host gives up after two lost cycles, then must wait a full round
        repeat (2) cycle(1, 1, 0, 32'h8, 32'h0, 1, 1, 32'h50, 32'hCAFE0001);
        cycle(1, 1, 0, 32'hC, 32'h0, 0, 0, 32'h0, 32'h0);
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            cycle(1, 1, 1, 32'h14, 32'(i), 1, 1, 32'h50, 32'hCAFE0002);
            @(negedge clk);
            #1;
            if (bus.host_gnt === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("cancel_wait", 128'(n), 128'(MAX_WAIT + 1));
        idle(1);

        // Reset lands between issue and return of a host read
        cycle(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h8, 32'h0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        streak = 0;
        exp_rd.delete();
        idle(0);
        idle(0);
        idle(1);
        idle(1);

        // Random traffic with protocol-legal holds, cancels and resets
        cr = 0; cw = 0; ca = 0; cwd = 0;
        hr = 0; hw = 0; ha = 0; hwd = 0;
        for (int k = 0; k < 500; k++) begin
            if (!(cr && !last_cg)) begin
                cr  = $urandom_range(0, 99) < 65;
                cw  = 1'($urandom_range(0, 1));
                ca  = rnd_addr();
                cwd = $urandom;
            end
            if (hr && !last_hg) begin
                if ($urandom_range(0, 99) < 5) hr = 0;
            end else begin
                hr  = $urandom_range(0, 99) < 40;
                hw  = 1'($urandom_range(0, 1));
                ha  = rnd_addr();
                hwd = $urandom;
            end
            r = $urandom_range(0, 99) >= 2;
            cycle(r, cr, cw, ca, cwd, hr, hw, ha, hwd);
        end

        idle(1);
        idle(1);
        @(negedge clk);
        #1;
        chk("drain", 128'(exp_rd.size()), 128'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-port data RAM between the pipeline MEM stage (CPU port) and a host/debug port (HOST port). It sits between the EX/MEM pipeline register and the RAM, issues at most one RAM access per cycle, and routes the one-cycle-late read data back to the port that issued the read. It stalls the pipeline when the host wins a contested cycle and bounds host starvation with a wait counter.

## Interface
- RAM_AW, 10: RAM word-address width
- DATA_W, 32: data width
- MAX_WAIT, 4: number of contested cycles the host loses before it is forced a grant; 0 means the host wins every contested cycle
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  MEM stage requests an access (load or store)
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address (ALU result)
- cpu_wdata  in  DATA_W  store data
- cpu_stall  out  1  CPU request not served this cycle; pipeline must hold
- cpu_rdata  out  DATA_W  load data
- cpu_rvalid  out  1  cpu_rdata valid
- host_req  in  1  host requests an access; held until host_gnt
- host_we  in  1  1 = write, 0 = read
- host_addr  in  32  byte address
- host_wdata  in  DATA_W  write data
- host_gnt  out  1  host access issued this cycle
- host_rdata  out  DATA_W  read data
- host_rvalid  out  1  host_rdata valid
- ram_address  out  RAM_AW  RAM word address
- ram_data  out  DATA_W  RAM write data
- ram_wren  out  1  RAM write enable
- ram_q  in  DATA_W  RAM read data, registered, valid one cycle after its address is presented

## Operation
- Word addressing: ram_address = addr[RAM_AW+1:2] of the granted port. Bits [1:0] are ignored. Upper bits are ignored, so out-of-range addresses wrap.
- Grant decision (combinational, every cycle):
  - Only cpu_req: CPU granted.
  - Only host_req: host granted.
  - Both, wait_cnt < MAX_WAIT: CPU granted.
  - Both, wait_cnt >= MAX_WAIT: host granted.
  - Neither: no access; ram_wren = 0, ram_address/ram_data = 0.
- Granted port drives ram_address and ram_data. ram_wren = granted port's we.
- cpu_stall = cpu_req & ~cpu_granted. host_gnt = host_granted.
- wait_cnt is 3 bits wide and saturates at 7.
  - Increments each cycle host_req = 1 and the host is not granted.
  - Clears when the host is granted or host_req = 0.
- Read-owner FSM, registered, with states IDLE, CPU_RD, HOST_RD:
  - Next state is CPU_RD if the CPU was granted with cpu_we = 0.
  - Next state is HOST_RD if the host was granted with host_we = 0.
  - Otherwise IDLE.
- Read return, driven in the cycle after issue:
  - In CPU_RD: cpu_rvalid = 1, cpu_rdata = ram_q.
  - In HOST_RD: host_rvalid = 1, host_rdata = ram_q.
  - The non-owning port's rdata is 0 and its rvalid is 0.
  - In IDLE: both rvalid = 0 and both rdata = 0.
- Writes produce no rvalid.
- Back-to-back reads from alternating ports each return in order, one per cycle.

## Timing
- Reset (rst = 0, asynchronous): FSM = IDLE, wait_cnt = 0. cpu_rvalid, host_rvalid, cpu_rdata and host_rdata are 0.
- During reset, grant logic is forced off: cpu_stall = 0, host_gnt = 0, ram_wren = 0, ram_address = 0, ram_data = 0.
- Reset mid-read: the pending return is discarded, and no rvalid is issued after reset is released.
- Grant, stall and RAM outputs are combinational from the requests and wait_cnt, with zero-cycle issue.
- Read latency is one cycle from issue to rvalid. rvalid is a single-cycle pulse per read.
- The host must hold host_req, host_we, host_addr and host_wdata stable until host_gnt = 1. Dropping host_req before the grant cancels the request and clears wait_cnt.
- While stalled, the CPU holds its request. The stalled request is served the next cycle it wins.
- Worst-case CPU stall per host access is 1 cycle when MAX_WAIT ≥ 1.
- Worst-case host wait is MAX_WAIT cycles under continuous CPU traffic.

## Test plan
- Reset behaviour: hold rst = 0 with cpu_req = 1 and host_req = 1 -> all outputs 0. Release rst, CPU read of addr 0x10 -> ram_address = 4 the same cycle, then cpu_rvalid = 1 and cpu_rdata = ram_q the next cycle.
- CPU store then load: store 0xDEADBEEF at 0x20, then load 0x20 -> ram_wren = 1 in cycle 0 with ram_address = 8, then cpu_rdata = 0xDEADBEEF one cycle after the load issues. No stall.
- Host starvation bound: cpu_req held at 1 with MAX_WAIT = 4, host read of 0x40 -> CPU granted for 4 cycles. On cycle 5, host_gnt = 1 and cpu_stall = 1. The next cycle host_rvalid = 1 and the CPU is regranted.
- Alternating reads: CPU read 0x0, then host read 0x4 in the following cycle -> cpu_rvalid on cycle 1 and host_rvalid on cycle 2, each carrying its own word and never crossed.
- Host cancel: host_req held for 2 contested cycles, then dropped -> wait_cnt returns to 0. A new host_req waits a full 4 cycles before being granted.
- Async reset mid-read: assert rst = 0 between issue and return of a host read -> host_rvalid stays 0 through reset and after release.
